odata_pio_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares the single 8-bit ODATA output PIO among several on-chip requesters. Each requester offers a byte over a valid/ready handshake. The arbiter grants one requester, issues the Avalon-MM write to PIO register 0, and optionally reads the value back to verify it. It then holds the byte on the PIO output for a programmable number of cycles before serving the next request. It sits between the requester logic and the PIO's Avalon slave in the Computer_System fabric.

---
 rtl/odata_pio_arbiter.sv | 155 +++++++++++++++
 tb/tb_odata_pio_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odata_pio_arbiter.sv
// Round-robin arbiter sharing the ODATA PIO; readback verify is built when ODATA_ARB_READBACK_EN is defined.
// Latency: accept in cycle 0, PIO write strobe in cycle 1, byte on out_port from cycle 2.
// Backpressure: one-cycle req_ready pulse in IDLE only; next accept after 2(+1 readback)+HOLD_CYCLES cycles.
module odata_pio_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [1:0]                 pio_address,
    output logic                       pio_chipselect,
    output logic                       pio_write_n,
    output logic [31:0]                pio_writedata,
    input  logic [31:0]                pio_readdata,
    output logic                       err_mismatch
);
    localparam int          GW        = $clog2(NUM_REQ);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

`ifdef ODATA_ARB_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_HOLD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    state_t            post_data_state;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic              found;
    logic [GW-1:0]     winner;
    logic              unused_rd;

    assign post_data_state = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
    assign unused_rd       = ^pio_readdata;

    // Search starts one past the last grant so a streaming requester cannot starve others.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[GW'(idx)]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

`ifdef ODATA_ARB_READBACK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        data_d         = data_q;
        hold_cnt_d     = hold_cnt_q;
        req_ready      = '0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
`ifdef ODATA_ARB_READBACK_EN
        err_d          = err_q;
`endif
        // Bus strobes and accepts are gated by reset so an in-flight byte is truly dropped.
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[winner] = ~reset;
                    last_grant_d      = winner;
                    grant_id_d        = winner;
                    data_d            = req_data[int'(winner)*DATA_W +: DATA_W];
                    state_d           = S_WRITE;
                end
            end
            S_WRITE: begin
                pio_chipselect = ~reset;
                pio_write_n    = reset;
`ifdef ODATA_ARB_READBACK_EN
                state_d        = S_READ;
`else
                state_d        = post_data_state;
                hold_cnt_d     = HOLD_LOAD;
`endif
            end
`ifdef ODATA_ARB_READBACK_EN
            S_READ: begin
                pio_chipselect = ~reset;
                if (pio_readdata[DATA_W-1:0] != data_q) begin
                    err_d = 1'b1;
                end
                state_d    = post_data_state;
                hold_cnt_d = HOLD_LOAD;
            end
`endif
            S_HOLD: begin
                if (hold_cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            data_q       <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            data_q       <= data_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

`ifdef ODATA_ARB_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

    assign grant_id      = grant_id_q;
    assign busy          = (state_q != S_IDLE);
    assign pio_address   = 2'b00;
    assign pio_writedata = {{(32-DATA_W){1'b0}}, data_q};

endmodule

// File: tb/tb_odata_pio_arbiter.sv
// Bench for odata_pio_arbiter: a PIO model plus scoreboard queues of expected grants and writes.
// A second instance with HOLD_CYCLES=0 covers the back-to-back accept case.
module tb_odata_pio_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 16;
`ifdef ODATA_ARB_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int GAP = 2 + HOLD + RB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic [1:0]        pio_address;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [31:0]       pio_writedata;
    logic [31:0]       pio_readdata;
    logic              err_mismatch;

    logic [7:0] pio_out   = 8'h00;
    logic       force_bad = 1'b0;
    assign pio_readdata = force_bad ? 32'h0 : {24'h0, pio_out};
    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n) pio_out <= pio_writedata[7:0];
    end

    odata_pio_arbiter #(.NUM_REQ(NREQ), .DATA_W(8), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata), .err_mismatch(err_mismatch)
    );

    logic [NREQ-1:0]   req_valid0 = '0;
    logic [NREQ*8-1:0] req_data0  = 32'h0000_BBAA;
    logic [NREQ-1:0]   req_ready0;
    logic [1:0]        grant_id0;
    logic              busy0;
    logic [1:0]        pio_address0;
    logic              pio_chipselect0;
    logic              pio_write_n0;
    logic [31:0]       pio_writedata0;
    logic              err_mismatch0;

    odata_pio_arbiter #(.NUM_REQ(NREQ), .DATA_W(8), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .grant_id(grant_id0), .busy(busy0),
        .pio_address(pio_address0), .pio_chipselect(pio_chipselect0),
        .pio_write_n(pio_write_n0), .pio_writedata(pio_writedata0),
        .pio_readdata(pio_writedata0), .err_mismatch(err_mismatch0)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_acc[$];
    logic [7:0] exp_wr[$];
    int         exp_acc0[$];
    int         cyc = 0;
    int         last_acc = -1;
    int         last_acc0 = -1;
    int         acc1_cyc = -1;
    bit         gap_chk = 1'b0;
    bit         wr_pend = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    bit         gid_pend = 1'b0;
    int         gid_exp = 0;
    int         rem[NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        int id;
        if (gid_pend) begin
            check("grant_id", 32'(grant_id), 32'(gid_exp));
            gid_pend = 1'b0;
        end
        if (wr_pend) begin
            check("out_port", 32'(pio_out), 32'(wr_byte));
            wr_pend = 1'b0;
        end
        if (busy && req_ready != '0) begin
            check("ready_while_busy", 32'(req_ready), 0);
        end else if (req_ready != '0) begin
            if (exp_acc.size() == 0) begin
                check("acc_unexpected", 32'(req_ready), 0);
            end else begin
                id = exp_acc.pop_front();
                check("acc_onehot", 32'(req_ready), 32'(1) << id);
                gid_pend = 1'b1;
                gid_exp  = id;
            end
            if (gap_chk && last_acc >= 0) check("acc_gap", cyc - last_acc, GAP);
            last_acc = cyc;
            if (req_ready[1]) acc1_cyc = cyc;
        end
        if (pio_chipselect && !pio_write_n) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(pio_chipselect & ~pio_write_n), 0);
            end else begin
                wr_byte = exp_wr.pop_front();
                check("wr_data", pio_writedata, {24'h0, wr_byte});
                check("wr_addr", 32'(pio_address), 0);
                check("wr_latency", cyc - last_acc, 1);
                wr_pend = 1'b1;
            end
        end
        if (pio_chipselect && pio_write_n) check("rd_latency", cyc - last_acc, 2);
        if (req_ready0 != '0) begin
            if (exp_acc0.size() == 0) begin
                check("acc0_unexpected", 32'(req_ready0), 0);
            end else begin
                id = exp_acc0.pop_front();
                check("acc0_onehot", 32'(req_ready0), 32'(1) << id);
            end
            if (last_acc0 >= 0) check("acc0_gap", cyc - last_acc0, 2 + RB);
            last_acc0 = cyc;
        end
    endtask

    // Sample at negedge, advance requester models just after the posedge.
    task automatic tick();
        logic [NREQ-1:0] seen;
        @(negedge clk);
        monitor();
        seen = req_ready;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (seen[i]) begin
                if (rem[i] > 0) begin
                    rem[i]--;
                    req_data[i*8 +: 8] = req_data[i*8 +: 8] + 8'h01;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic offer(input int i, input logic [7:0] b, input int r);
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = b;
        rem[i]             = r;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || req_valid != '0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check("timeout", {30'b0, busy, |req_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cs"}, 32'(pio_chipselect), 0);
        check({tag, "_write_n"}, 32'(pio_write_n), 1);
        check({tag, "_addr"}, 32'(pio_address), 0);
        check({tag, "_wdata"}, pio_writedata, 0);
        check({tag, "_err"}, 32'(err_mismatch), 0);
    endtask

    initial begin
        int t1;
        int n;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("rst");

        // Single request from requester 0
        offer(0, 8'hA5, 0);
        exp_acc.push_back(0);
        exp_wr.push_back(8'hA5);
        wait_idle(100);
        check("t1_busy_len", cyc - last_acc, 2 + HOLD + RB);
        check("t1_out", 32'(pio_out), 32'hA5);

        // All four contend from reset: 0,1,2,3 then requester 0 again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gap_chk  = 1'b1;
        last_acc = -1;
        offer(0, 8'h10, 1);
        offer(1, 8'h20, 0);
        offer(2, 8'h30, 0);
        offer(3, 8'h40, 0);
        exp_acc.push_back(0); exp_acc.push_back(1); exp_acc.push_back(2);
        exp_acc.push_back(3); exp_acc.push_back(0);
        exp_wr.push_back(8'h10); exp_wr.push_back(8'h20); exp_wr.push_back(8'h30);
        exp_wr.push_back(8'h40); exp_wr.push_back(8'h11);
        wait_idle(300);

        // Requester 2 streams; requester 1 asserts once mid-hold
        last_acc = -1;
        acc1_cyc = -1;
        offer(2, 8'h2C, 3);
        exp_acc.push_back(2); exp_acc.push_back(1); exp_acc.push_back(2);
        exp_acc.push_back(2); exp_acc.push_back(2);
        exp_wr.push_back(8'h2C); exp_wr.push_back(8'h1B); exp_wr.push_back(8'h2D);
        exp_wr.push_back(8'h2E); exp_wr.push_back(8'h2F);
        repeat (5) tick();
        t1 = cyc;
        offer(1, 8'h1B, 0);
        wait_idle(300);
        check("t3_r1_wait", acc1_cyc - t1, GAP - 5);
        gap_chk = 1'b0;

        // Corrupted readback sets the sticky error (tied low without readback)
        force_bad = 1'b1;
        offer(3, 8'h5A, 0);
        exp_acc.push_back(3);
        exp_wr.push_back(8'h5A);
        wait_idle(100);
        force_bad = 1'b0;
        check("t4_err_set", 32'(err_mismatch), RB);
        offer(0, 8'h33, 0);
        exp_acc.push_back(0);
        exp_wr.push_back(8'h33);
        wait_idle(100);
        check("t4_err_sticky", 32'(err_mismatch), RB);

        // Reset during WRITE: no strobe, byte dropped, requester 0 wins next
        offer(1, 8'h77, 0);
        exp_acc.push_back(1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst5");
        check("rst5_pio_keeps", 32'(pio_out), 32'h33);
        gap_chk  = 1'b1;
        last_acc = -1;
        offer(0, 8'h44, 0);
        offer(1, 8'h55, 0);
        exp_acc.push_back(0); exp_acc.push_back(1);
        exp_wr.push_back(8'h44); exp_wr.push_back(8'h55);
        wait_idle(200);
        gap_chk = 1'b0;

        // HOLD_CYCLES=0 instance, two requesters always valid
        for (int k = 0; k < 3; k++) begin
            exp_acc0.push_back(0);
            exp_acc0.push_back(1);
        end
        req_valid0 = 4'b0011;
        n = 0;
        while (exp_acc0.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        req_valid0 = '0;
        check("t6_all_accepted", exp_acc0.size(), 0);
        repeat (6) tick();

        check("sb_acc_left", exp_acc.size(), 0);
        check("sb_wr_left", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
